detect_58: RTL and testbench

DETECT_58 -- requirements
Module: detect_58

---
 rtl/detect_58_pkg.sv | 19 +
 rtl/detect_58_if.sv | 17 +
 rtl/detect_58_reg.sv | 19 +
 rtl/detect_58.sv | 45 ++++
 tb/tb_detect_58.sv | 200 ++++++++++++++++++++
 5 files changed

// File: rtl/detect_58_pkg.sv
// detect_58 shared definitions: state codes for the
// "0101 1000" serial pattern detector.
package detect_58_pkg;

    localparam logic [3:0] S0 = 4'd0;
    localparam logic [3:0] S1 = 4'd1;
    localparam logic [3:0] S2 = 4'd2;
    localparam logic [3:0] S3 = 4'd3;
    localparam logic [3:0] S4 = 4'd4;
    localparam logic [3:0] S5 = 4'd5;
    localparam logic [3:0] S6 = 4'd6;
    localparam logic [3:0] S7 = 4'd7;
    localparam logic [3:0] S8 = 4'd8;

    function automatic logic is_match(input logic [3:0] s);
        return s == S8;
    endfunction

endpackage

// File: rtl/detect_58_if.sv
// detect_58 bundles: state register bus and the
// serial in/detect pair used around the block.
interface detect_58_if;
    logic [3:0] d;
    logic [3:0] q;

    modport master (output d, input q);
    modport slave  (input d, output q);
endinterface

interface detect_58_ser_if;
    logic din;
    logic det;

    modport master (output din, input det);
    modport slave  (input din, output det);
endinterface

// File: rtl/detect_58_reg.sv
// detect_58 state register: 4 bits, async
// active-low reset to S0.
module detect_58_reg
    import detect_58_pkg::*;
(
    input logic        clk,
    input logic        rst_n,
    detect_58_if.slave bus
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus.q <= S0;
        end else begin
            bus.q <= bus.d;
        end
    end

endmodule

// File: rtl/detect_58.sv
// detect_58: Moore detector for BCD "5","8" (0101 1000),
// overlapping matches; out high while in S8.
module detect_58
    import detect_58_pkg::*;
(
    input  logic in,
    input  logic clk,
    input  logic rst,
    output logic out
);

    detect_58_if bus ();

    logic [3:0] state;
    logic [3:0] state_d;

    detect_58_reg u_reg (
        .clk   (clk),
        .rst_n (rst),
        .bus   (bus.slave)
    );

    assign state = bus.q;
    assign bus.d = state_d;

    // Each arc falls back to the longest prefix still matching.
    always_comb begin
        state_d = S0;
        unique case (state)
            S0:      state_d = in ? S0 : S1;
            S1:      state_d = in ? S2 : S1;
            S2:      state_d = in ? S0 : S3;
            S3:      state_d = in ? S4 : S1;
            S4:      state_d = in ? S5 : S3;
            S5:      state_d = in ? S0 : S6;
            S6:      state_d = in ? S2 : S7;
            S7:      state_d = in ? S2 : S8;
            S8:      state_d = in ? S2 : S1;
            default: state_d = S0;
        endcase
    end

    assign out = is_match(state);

endmodule

// File: tb/tb_detect_58.sv
// Directed testbench for detect_58.
// Hand-computed state/out sequences per scenario.
module tb_detect_58;
    import detect_58_pkg::*;

    logic clk;
    logic rst;
    int   tests;
    int   failed;

    detect_58_ser_if ser ();

    detect_58 dut (
        .in  (ser.din),
        .clk (clk),
        .rst (rst),
        .out (ser.det)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick(input logic b);
        @(negedge clk);
        ser.din = b;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        @(negedge clk);
        rst = 1'b1;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        ser.din = 1'b0;
        for (int i = 0; i < 6; i++) begin
            tick(1'($urandom_range(0, 1)));
            tests++;
            if (dut.state !== S0 || ser.det !== 1'b0) begin
                failed++;
                $display("FAIL reset[%0d]: state=%0d out=%b, want state=0 out=0",
                         i, dut.state, ser.det);
            end
        end
        @(negedge clk);
        rst = 1'b1;
    endtask

    task automatic test_single();
        logic       b [9] = '{0,1,0,1,1,0,0,0,0};
        logic [3:0] e [9] = '{1,2,3,4,5,6,7,8,1};
        do_reset();
        for (int i = 0; i < 9; i++) begin
            tick(b[i]);
            tests++;
            if (dut.state !== e[i] || ser.det !== (e[i] == S8)) begin
                failed++;
                $display("FAIL single[%0d]: state=%0d out=%b, want state=%0d out=%b",
                         i, dut.state, ser.det, e[i], (e[i] == S8));
            end
        end
    endtask

    task automatic test_overlap();
        logic       b [21] = '{0,0,0,1,0,0,1,0,1,0,1,1,0,1,0,1,1,0,0,0,0};
        logic [3:0] e [21] = '{1,1,1,2,3,1,2,3,4,3,4,5,6,2,3,4,5,6,7,8,1};
        int hits;
        hits = 0;
        do_reset();
        for (int i = 0; i < 21; i++) begin
            tick(b[i]);
            if (ser.det === 1'b1) hits++;
            tests++;
            if (dut.state !== e[i] || ser.det !== (e[i] == S8)) begin
                failed++;
                $display("FAIL overlap[%0d]: state=%0d out=%b, want state=%0d out=%b",
                         i, dut.state, ser.det, e[i], (e[i] == S8));
            end
        end
        tests++;
        if (hits !== 1) begin
            failed++;
            $display("FAIL overlap_count: pulses=%0d, want 1", hits);
        end
    endtask

    task automatic test_fallback();
        logic       b [17] = '{0,1,1, 0,1,0,1,1,1, 0,1,0,1,1,0,0,1};
        logic [3:0] e [17] = '{1,2,0, 1,2,3,4,5,0, 1,2,3,4,5,6,7,2};
        do_reset();
        for (int i = 0; i < 17; i++) begin
            tick(b[i]);
            tests++;
            if (dut.state !== e[i] || ser.det !== 1'b0) begin
                failed++;
                $display("FAIL fallback[%0d]: state=%0d out=%b, want state=%0d out=0",
                         i, dut.state, ser.det, e[i]);
            end
        end
    endtask

    task automatic test_back_to_back();
        logic       b [17] = '{0,1,0,1,1,0,0,0, 0,1,0,1,1,0,0,0, 1};
        logic [3:0] e [17] = '{1,2,3,4,5,6,7,8, 1,2,3,4,5,6,7,8, 2};
        int first;
        int second;
        first  = -1;
        second = -1;
        do_reset();
        for (int i = 0; i < 17; i++) begin
            tick(b[i]);
            if (ser.det === 1'b1) begin
                if (first < 0) first = i;
                else second = i;
            end
            tests++;
            if (dut.state !== e[i] || ser.det !== (e[i] == S8)) begin
                failed++;
                $display("FAIL b2b[%0d]: state=%0d out=%b, want state=%0d out=%b",
                         i, dut.state, ser.det, e[i], (e[i] == S8));
            end
        end
        tests++;
        if (first !== 7 || second !== 15) begin
            failed++;
            $display("FAIL b2b_spacing: pulses at %0d,%0d, want 7,15",
                     first, second);
        end
    endtask

    task automatic test_all_ones();
        do_reset();
        for (int i = 0; i < 10; i++) begin
            tick(1'b1);
            tests++;
            if (dut.state !== S0 || ser.det !== 1'b0) begin
                failed++;
                $display("FAIL ones[%0d]: state=%0d out=%b, want state=0 out=0",
                         i, dut.state, ser.det);
            end
        end
    endtask

    task automatic test_async_reset();
        logic       b [6] = '{0,1,0,1,1,0};
        logic       p [8] = '{0,1,0,1,1,0,0,0};
        logic [3:0] e [8] = '{1,2,3,4,5,6,7,8};
        do_reset();
        for (int i = 0; i < 6; i++) tick(b[i]);
        tests++;
        if (dut.state !== S6) begin
            failed++;
            $display("FAIL async_pre: state=%0d, want 6", dut.state);
        end
        #2;
        rst = 1'b0;
        #1;
        tests++;
        if (dut.state !== S0 || ser.det !== 1'b0) begin
            failed++;
            $display("FAIL async_now: state=%0d out=%b, want state=0 out=0",
                     dut.state, ser.det);
        end
        @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        for (int i = 0; i < 8; i++) begin
            tick(p[i]);
            tests++;
            if (dut.state !== e[i] || ser.det !== (e[i] == S8)) begin
                failed++;
                $display("FAIL async_post[%0d]: state=%0d out=%b, want state=%0d out=%b",
                         i, dut.state, ser.det, e[i], (e[i] == S8));
            end
        end
    endtask

    initial begin
        tests   = 0;
        failed  = 0;
        rst     = 1'b0;
        ser.din = 1'b0;
        test_reset();
        test_single();
        test_overlap();
        test_fallback();
        test_back_to_back();
        test_all_ones();
        test_async_reset();
        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
